// File: rtl/spi_pkg.sv
// Shared constants for the SPI register-access arbiter: FSM encoding,
// requester count and the default transaction timeout.
package spi_pkg;

  localparam int unsigned NREQ = 4;
  localparam logic [15:0] TIMEOUT_CYC_DEF = 16'd65535;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_CLR  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

endpackage

// File: rtl/spi_arbiter_rr.sv
// Combinational round-robin pick: the search starts one past last_gnt and
// wraps, so the previous winner has the lowest priority.
module rr_arbiter
  import spi_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last_gnt,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      index
);

  logic       found;
  logic [1:0] cand;

  always_comb begin
    gnt   = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_gnt + 2'(k);
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        index      = cand;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates four register-access requesters onto one SPI master and
// returns a one-cycle ack with read data or a timeout error.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [3:0]  req_rw,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        spi_start_w,
  output logic        spi_start_r,
  output logic [7:0]  spi_addr,
  output logic [7:0]  spi_wdata,
  input  logic [7:0]  spi_rdata,
  input  logic        spi_done
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic        rw_q, rw_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] tmo_inc;
  logic [3:0]  arb_gnt;
  logic [1:0]  arb_idx;
  logic        in_resp;

  rr_arbiter u_rr (
    .req      (req),
    .last_gnt (last_q),
    .gnt      (arb_gnt),
    .index    (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    tmo_inc = tmo_q + 16'd1;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          rw_d    = req_rw[arb_idx];
          addr_d  = req_addr[{arb_idx, 3'b000} +: 8];
          wdata_d = req_wdata[{arb_idx, 3'b000} +: 8];
          err_d   = 1'b0;
          tmo_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TIMEOUT_CYC) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if (!spi_done) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmo_d = tmo_inc;
        // A frame finishing on the timeout cycle is reported as a success.
        if (spi_done) begin
          state_d = ST_RESP;
        end else if (tmo_inc == TIMEOUT_CYC) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d   = '0;
        last_d  = idx_q;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 2'd3;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Pulse outputs decode the registered state so reset clears them at once.
  assign in_resp     = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign gnt         = gnt_q;
  assign ack         = in_resp ? gnt_q : '0;
  assign rsp_err     = in_resp & err_q;
  assign rsp_rdata   = (in_resp && rw_q && !err_q) ? spi_rdata : 8'h00;
  assign spi_start_w = (state_q == ST_ISSUE) & ~rw_q;
  assign spi_start_r = (state_q == ST_ISSUE) & rw_q;
  assign spi_addr    = addr_q;
  assign spi_wdata   = wdata_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter with a behavioural SPI master and a
// transaction-level round-robin reference model.
module tb_spi_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req, req_rw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  gnt, ack;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, busy, spi_start_w, spi_start_r;
  logic [7:0]  spi_addr, spi_wdata, spi_rdata;
  logic        spi_done;

  spi_arbiter #(.TIMEOUT_CYC(16'd100)) dut (
    .clock(clock), .reset(reset), .req(req), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .spi_start_w(spi_start_w), .spi_start_r(spi_start_r),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_done(spi_done)
  );

  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Read-only slave: register value is its address xor a fixed key.
  function automatic logic [7:0] slave_rd(input logic [7:0] a);
    return a ^ 8'h2C;
  endfunction

  function automatic int unsigned rr_pick(input logic [3:0] r, input int unsigned last);
    for (int unsigned k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  // SPI master: done drops two cycles after a start, rises frame_len later.
  logic        tie0 = 1'b0;
  int unsigned frame_len = 4;
  logic [1:0]  mphase;
  int unsigned mcnt;
  logic        m_rw;
  logic [7:0]  m_addr;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      spi_done  <= 1'b0;
      spi_rdata <= 8'h00;
      mphase    <= 2'd0;
      mcnt      <= 0;
      m_rw      <= 1'b0;
      m_addr    <= 8'h00;
    end else begin
      case (mphase)
        2'd0: if (spi_start_w || spi_start_r) begin
          mphase <= 2'd1;
          mcnt   <= 1;
          m_rw   <= spi_start_r;
          m_addr <= spi_addr;
        end
        2'd1: if (mcnt == 0) begin
          spi_done <= 1'b0;
          mphase   <= 2'd2;
          mcnt     <= frame_len;
        end else mcnt <= mcnt - 1;
        2'd2: if (!tie0) begin
          if (mcnt == 0) begin
            spi_done <= 1'b1;
            mphase   <= 2'd0;
            if (m_rw) spi_rdata <= slave_rd(m_addr);
          end else mcnt <= mcnt - 1;
        end
        default: mphase <= 2'd0;
      endcase
    end
  end

  typedef struct {
    int unsigned idx;
    logic        rw;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int unsigned flen;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_rdata;
  } txn_t;

  txn_t tbl[6];

  task automatic wait_busy(output int unsigned n);
    n = 0;
    while (!busy && n < 100) begin @(negedge clock); n++; end
  endtask

  task automatic wait_ack(output int unsigned n);
    n = 0;
    while (ack == 4'b0 && n < 1000) begin @(negedge clock); n++; end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    req   = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_txn(input txn_t t);
    int unsigned n;
    req_rw[t.idx]           = t.rw;
    req_addr[8*t.idx +: 8]  = t.addr;
    req_wdata[8*t.idx +: 8] = t.wdata;
    frame_len               = t.flen;
    req[t.idx]              = 1'b1;
    wait_busy(n);
    chk("start_latency", n, 1);
    chk("grant", gnt, t.exp_gnt);
    chk("start_w", spi_start_w, !t.rw);
    chk("start_r", spi_start_r, t.rw);
    chk("spi_addr", spi_addr, t.addr);
    if (!t.rw) chk("spi_wdata", spi_wdata, t.wdata);
    @(negedge clock);
    chk("start_single", {spi_start_w, spi_start_r}, 0);
    wait_ack(n);
    chk("ack", ack, t.exp_gnt);
    chk("gnt_in_ack", gnt, t.exp_gnt);
    chk("rdata", rsp_rdata, t.exp_rdata);
    chk("err", rsp_err, 0);
    req[t.idx] = 1'b0;
    @(negedge clock);
    chk("ack_one_cycle", ack, 0);
    chk("gnt_cleared", gnt, 0);
  endtask

  initial begin
    int unsigned n, c, m_last, pend_idx, brun;
    logic        saw_low, any_ack, prev_busy, pend_rw;
    logic [7:0]  pend_addr;

    tbl[0] = '{0, 1'b0, 8'h55, 8'hAA, 32, 4'b0001, 8'h00};
    tbl[1] = '{2, 1'b1, 8'h10, 8'h00, 10, 4'b0100, 8'h3C};
    tbl[2] = '{1, 1'b1, 8'hF0, 8'h00, 3,  4'b0010, 8'hDC};
    tbl[3] = '{3, 1'b0, 8'h00, 8'h5A, 1,  4'b1000, 8'h00};
    tbl[4] = '{3, 1'b1, 8'hFF, 8'h00, 2,  4'b1000, 8'hD3};
    tbl[5] = '{0, 1'b1, 8'h2C, 8'h11, 0,  4'b0001, 8'h00};

    reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_starts", {spi_start_w, spi_start_r}, 0);
    chk("rst_payload", {spi_addr, spi_wdata}, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (tbl[i]) run_txn(tbl[i]);

    // Round-robin fairness with all four requests held.
    pulse_reset();
    frame_len = 3;
    req_rw = 4'b0000;
    req_addr = 32'h44332211;
    req = 4'b1111;
    m_last = 3;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      m_last = rr_pick(4'b1111, m_last);
      chk("fair_order", ack, 32'(1 << m_last));
      @(negedge clock);
    end
    req = '0;
    wait_busy(n);
    wait_ack(n);
    @(negedge clock);

    // Back-to-back read on requester 1 while done is still high.
    pulse_reset();
    frame_len = 4;
    req_rw[1] = 1'b1;
    req_addr[15:8] = 8'h21;
    req[1] = 1'b1;
    wait_ack(n);
    chk("b2b_first_rdata", rsp_rdata, 8'h0D);
    req_addr[15:8] = 8'h47;
    @(negedge clock);
    wait_busy(n);
    chk("b2b_stale_done", spi_done, 1);
    chk("b2b_start_r", spi_start_r, 1);
    saw_low = 1'b0;
    c = 0;
    while (ack == 4'b0 && c < 1000) begin
      @(negedge clock);
      if (!spi_done) saw_low = 1'b1;
      c++;
    end
    chk("b2b_waited_clear", saw_low, 1);
    chk("b2b_ack", ack, 4'b0010);
    chk("b2b_second_rdata", rsp_rdata, 8'h6B);
    req = '0;

    // Timeout with the master never finishing.
    pulse_reset();
    tie0 = 1'b1;
    req_rw[3] = 1'b1;
    req_addr[31:24] = 8'h77;
    req[3] = 1'b1;
    wait_busy(n);
    c = 0;
    while (ack == 4'b0 && c < 300) begin @(negedge clock); c++; end
    chk("tmo_latency", c, 101);
    chk("tmo_ack", ack, 4'b1000);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_rdata", rsp_rdata, 8'h00);
    tie0 = 1'b0;
    req = '0;

    // Reset in the middle of WAIT_DONE.
    pulse_reset();
    frame_len = 20;
    req_rw[2] = 1'b1;
    req_addr[23:16] = 8'h33;
    req[2] = 1'b1;
    wait_busy(n);
    c = 0;
    while (spi_done && c < 20) begin @(negedge clock); c++; end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_starts", {spi_start_w, spi_start_r}, 0);
    chk("mid_rst_payload", {spi_addr, spi_wdata}, 0);
    chk("mid_rst_rsp", {rsp_rdata, 7'b0, rsp_err}, 0);
    @(negedge clock);
    reset = 1'b1;
    any_ack = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (ack != 4'b0) any_ack = 1'b1;
    end
    chk("mid_rst_no_ack", any_ack, 0);
    run_txn(tbl[0]);

    // Randomised traffic against the transaction-level model.
    pulse_reset();
    m_last = 3; prev_busy = 1'b0; pend_idx = 0; pend_rw = 1'b0;
    pend_addr = 8'h00; brun = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      chk("rnd_start_excl", spi_start_w & spi_start_r, 0);
      if (busy && !prev_busy) begin
        pend_idx  = rr_pick(req, m_last);
        pend_rw   = req_rw[pend_idx];
        pend_addr = req_addr[8*pend_idx +: 8];
        chk("rnd_gnt", gnt, 32'(1 << pend_idx));
        chk("rnd_start", {spi_start_r, spi_start_w}, pend_rw ? 2 : 1);
        chk("rnd_addr", spi_addr, pend_addr);
      end
      if (!busy) chk("rnd_idle_gnt", gnt, 0);
      if (ack != 4'b0) begin
        chk("rnd_ack", ack, 32'(1 << pend_idx));
        chk("rnd_rdata", rsp_rdata, pend_rw ? slave_rd(pend_addr) : 8'h00);
        chk("rnd_err", rsp_err, 0);
        m_last = pend_idx;
      end
      brun = busy ? brun + 1 : 0;
      if (brun > 200) begin
        chk("rnd_watchdog", brun, 0);
        break;
      end
      prev_busy = busy;
      frame_len = $urandom_range(0, 8);
      for (int i = 0; i < 4; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req_rw[i]         = 1'($urandom_range(0, 1));
          req_addr[8*i +: 8]  = 8'($urandom);
          req_wdata[8*i +: 8] = 8'($urandom);
          req[i]            = 1'b1;
        end else if (req[i] && gnt[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
